// File: rtl/i2c_master_if.sv
// Command/response handshake between a host and the i2c_master byte engine.
interface i2c_master_if;
    logic       iCMD_VALID;
    logic       oCMD_READY;
    logic [1:0] iCMD;
    logic [7:0] iWDATA;
    logic       iMACK;
    logic       oDONE;
    logic [7:0] oRDATA;
    logic       oSACK;

    modport master (
        output iCMD_VALID, iCMD, iWDATA, iMACK,
        input  oCMD_READY, oDONE, oRDATA, oSACK
    );

    modport slave (
        input  iCMD_VALID, iCMD, iWDATA, iMACK,
        output oCMD_READY, oDONE, oRDATA, oSACK
    );
endinterface

// File: rtl/i2c_master.sv
// Byte-level I2C master: START/STOP/WRITE/READ commands, each bus phase split into quarters.
// Define I2C_MASTER_STRETCH_EN to freeze the q2 high phase while a slave holds iSCL_IN low.
module i2c_master #(
    parameter int DIVIDER = 120
) (
    input  logic        iCLK,
    input  logic        iRESET,
    i2c_master_if.slave cmdIf,
    output logic        oSCL,
    input  logic        iSCL_IN,
    inout  wire         bSDA
);
    typedef enum logic [2:0] {IDLE, START, STOP, BIT, ACK, DONE} state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;
    localparam logic [9:0] DIV_LAST  = 10'(DIVIDER - 1);

    state_t     state;
    logic [9:0] divCnt;
    logic [1:0] qCnt;
    logic [2:0] bitCnt;
    logic [1:0] cmdReg;
    logic [7:0] wdataReg;
    logic       mackReg;
    logic [7:0] rxShift;
    logic       sackShadow;
    logic       sdaLow;
    logic       cmdReady;
    logic       done;
    logic [7:0] rdata;
    logic       sack;
    logic       freeze;

    assign bSDA             = sdaLow ? 1'b0 : 1'bz;
    assign cmdIf.oCMD_READY = cmdReady;
    assign cmdIf.oDONE      = done;
    assign cmdIf.oRDATA     = rdata;
    assign cmdIf.oSACK      = sack;

`ifdef I2C_MASTER_STRETCH_EN
    assign freeze = (qCnt == 2'd2) && oSCL && !iSCL_IN;
`else
    logic unusedSclIn;
    assign unusedSclIn = iSCL_IN;
    assign freeze      = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state    <= IDLE;
            divCnt   <= '0;
            qCnt     <= '0;
            bitCnt   <= '0;
            oSCL     <= 1'b1;
            sdaLow   <= 1'b0;
            cmdReady <= 1'b1;
            done     <= 1'b0;
            rdata    <= 8'h00;
            sack     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmdIf.iCMD_VALID && cmdReady) begin
                        cmdReg   <= cmdIf.iCMD;
                        wdataReg <= cmdIf.iWDATA;
                        mackReg  <= cmdIf.iMACK;
                        cmdReady <= 1'b0;
                        divCnt   <= '0;
                        qCnt     <= '0;
                        bitCnt   <= '0;
                        case (cmdIf.iCMD)
                            CMD_START: state <= START;
                            CMD_STOP:  state <= STOP;
                            default:   state <= BIT;
                        endcase
                    end
                end

                DONE: begin
                    done     <= 1'b1;
                    cmdReady <= 1'b1;
                    state    <= IDLE;
                    if (cmdReg == CMD_READ)  rdata <= rxShift;
                    if (cmdReg == CMD_WRITE) sack  <= sackShadow;
                    // Byte transfers end in a high SCL phase; park SCL low so the bus waits in a data phase.
                    if (cmdReg[1]) oSCL <= 1'b0;
                end

                default: begin
                    // Line levels follow the current quarter; SDA moves one cycle into q0 so it never races SCL.
                    case (state)
                        START: begin
                            case (qCnt)
                                2'd0:    if (divCnt == 10'd1) sdaLow <= 1'b0;
                                2'd1:    oSCL   <= 1'b1;
                                2'd2:    sdaLow <= 1'b1;
                                default: oSCL   <= 1'b0;
                            endcase
                        end
                        STOP: begin
                            case (qCnt)
                                2'd0: begin
                                    oSCL <= 1'b0;
                                    if (divCnt == 10'd1) sdaLow <= 1'b1;
                                end
                                2'd1:    oSCL   <= 1'b1;
                                2'd2:    sdaLow <= 1'b0;
                                default: ;
                            endcase
                        end
                        default: begin
                            oSCL <= qCnt[1];
                            if (qCnt == 2'd0 && divCnt == 10'd1) begin
                                if (state == BIT)
                                    sdaLow <= (cmdReg == CMD_WRITE) && !wdataReg[3'd7 - bitCnt];
                                else
                                    sdaLow <= (cmdReg == CMD_READ) && mackReg;
                            end
                        end
                    endcase

                    if (qCnt == 2'd3 && divCnt == 10'd0) begin
                        if (state == BIT) rxShift[3'd7 - bitCnt] <= bSDA;
                        if (state == ACK) sackShadow <= !bSDA;
                    end

                    if (!freeze) begin
                        if (divCnt == DIV_LAST) begin
                            divCnt <= '0;
                            qCnt   <= qCnt + 2'd1;
                            if (qCnt == 2'd3) begin
                                case (state)
                                    BIT: begin
                                        if (bitCnt == 3'd7) state <= ACK;
                                        else bitCnt <= bitCnt + 3'd1;
                                    end
                                    default: state <= DONE;
                                endcase
                            end
                        end else begin
                            divCnt <= divCnt + 10'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master at DIVIDER=4 with a small I2C slave model on SDA.
module tb_i2c_master;
    localparam int D = 4;

    logic iCLK = 1'b0;
    logic iRESET = 1'b1;
    always #5 iCLK = ~iCLK;

    i2c_master_if ifc();
    logic oSCL;
    logic sclIn;
    logic stretchHold = 1'b0;
    wire  sda;
    logic slaveLow;
    logic sdaLvl;

    i2c_master #(.DIVIDER(D)) dut (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .cmdIf   (ifc),
        .oSCL    (oSCL),
        .iSCL_IN (sclIn),
        .bSDA    (sda)
    );

    pullup (sda);
    assign sda    = slaveLow ? 1'b0 : 1'bz;
    assign sdaLvl = sda;
    assign sclIn  = oSCL & ~stretchHold;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Slave model: counts SCL falls since the command was accepted, captures SDA on SCL rises.
    logic [1:0] slaveMode = 2'd0;  // 0 passive, 1 ACK a write, 2 send slaveByte
    logic [7:0] slaveByte = 8'h00;
    logic       slaveClr = 1'b0;
    int         falls = 0;
    int         capCnt = 0;
    logic [7:0] capByte = 8'h00;
    logic       ackBit = 1'b1;
    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    int         startCnt = 0;
    int         stopCnt = 0;

    assign slaveLow = (slaveMode == 2'd2 && falls < 8 && !slaveByte[3'(7 - falls)]) ||
                      (slaveMode == 2'd1 && falls == 8);

    always @(posedge iCLK) begin
        prevScl <= oSCL;
        prevSda <= sdaLvl;
        if (prevScl && oSCL && prevSda && !sdaLvl) startCnt <= startCnt + 1;
        if (prevScl && oSCL && !prevSda && sdaLvl) stopCnt <= stopCnt + 1;
        if (slaveClr) begin
            falls   <= 0;
            capCnt  <= 0;
            capByte <= 8'h00;
        end else begin
            if (prevScl && !oSCL) falls <= falls + 1;
            if (!prevScl && oSCL) begin
                if (capCnt < 8) capByte <= {capByte[6:0], sdaLvl};
                else if (capCnt == 8) ackBit <= sdaLvl;
                capCnt <= capCnt + 1;
            end
        end
    end

    int nChecks = 0;
    int nFail = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] w, input logic m, output int e);
        @(negedge iCLK);
        ifc.iCMD_VALID = 1'b1;
        ifc.iCMD       = c;
        ifc.iWDATA     = w;
        ifc.iMACK      = m;
        slaveClr       = 1'b1;
        @(posedge iCLK);
        #1;
        e              = cyc;
        ifc.iCMD_VALID = 1'b0;
        slaveClr       = 1'b0;
    endtask

    task automatic waitDone(input int e, input int limit, output int lat, output logic rdy);
        lat = -1;
        rdy = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge iCLK);
            #1;
            if (ifc.oDONE) begin
                lat = cyc - e;
                rdy = ifc.oCMD_READY;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic       mack;
        logic [1:0] smode;
        logic [7:0] sbyte;
        int         lat;
        logic [7:0] rdata;
        logic       sack;
        logic       chkCap;
        logic [7:0] cap;
        logic       ackb;
        logic       scl;
        logic       sdaExp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   e;
        int   lat;
        logic rdy;
        int   doneSeen;

        //            cmd    wdata  mk  sm     sbyte  lat  rdata  sk  chk cap    ab  scl sda
        vecs[0]  = '{2'b00, 8'h00, 0, 2'd0, 8'h00, 17,  8'h00, 0, 0, 8'h00, 0, 0, 0};
        vecs[1]  = '{2'b10, 8'hA5, 0, 2'd1, 8'h00, 145, 8'h00, 1, 1, 8'hA5, 0, 0, 1};
        vecs[2]  = '{2'b10, 8'h5A, 0, 2'd0, 8'h00, 145, 8'h00, 0, 1, 8'h5A, 1, 0, 1};
        vecs[3]  = '{2'b00, 8'h00, 0, 2'd0, 8'h00, 17,  8'h00, 0, 0, 8'h00, 0, 0, 0};
        vecs[4]  = '{2'b11, 8'h00, 0, 2'd2, 8'h3C, 145, 8'h3C, 0, 1, 8'h3C, 1, 0, 1};
        vecs[5]  = '{2'b11, 8'h00, 1, 2'd2, 8'hC3, 145, 8'hC3, 0, 1, 8'hC3, 0, 0, 0};
        vecs[6]  = '{2'b01, 8'h00, 0, 2'd0, 8'h00, 17,  8'hC3, 0, 0, 8'h00, 0, 1, 1};
        vecs[7]  = '{2'b00, 8'h00, 0, 2'd0, 8'h00, 17,  8'hC3, 0, 0, 8'h00, 0, 0, 0};
        vecs[8]  = '{2'b10, 8'hFF, 0, 2'd1, 8'h00, 145, 8'hC3, 1, 1, 8'hFF, 0, 0, 1};
        vecs[9]  = '{2'b11, 8'h00, 0, 2'd2, 8'h00, 145, 8'h00, 1, 1, 8'h00, 1, 0, 1};
        vecs[10] = '{2'b01, 8'h00, 0, 2'd0, 8'h00, 17,  8'h00, 1, 0, 8'h00, 0, 1, 1};

        ifc.iCMD_VALID = 1'b0;
        ifc.iCMD       = 2'b00;
        ifc.iWDATA     = 8'h00;
        ifc.iMACK      = 1'b0;

        repeat (3) @(posedge iCLK);
        #1;
        check("reset_ready", ifc.oCMD_READY, 1);
        check("reset_done", ifc.oDONE, 0);
        check("reset_rdata", ifc.oRDATA, 8'h00);
        check("reset_sack", ifc.oSACK, 0);
        check("reset_scl", oSCL, 1);
        check("reset_sda", sdaLvl, 1);

        // START presented in the same cycle reset drops
        @(negedge iCLK);
        iRESET         = 1'b0;
        ifc.iCMD_VALID = 1'b1;
        ifc.iCMD       = 2'b00;
        slaveClr       = 1'b1;
        @(posedge iCLK);
        #1;
        e              = cyc;
        ifc.iCMD_VALID = 1'b0;
        slaveClr       = 1'b0;
        check("busy_after_accept", ifc.oCMD_READY, 0);
        waitDone(e, 300, lat, rdy);
        check("first_start_latency", lat, 17);
        check("first_start_ready", rdy, 1);
        check("first_start_scl", oSCL, 0);
        check("first_start_cond", startCnt, 1);
        repeat (2) @(posedge iCLK);

        for (int i = 0; i < 11; i++) begin
            slaveMode = vecs[i].smode;
            slaveByte = vecs[i].sbyte;
            issue(vecs[i].cmd, vecs[i].wdata, vecs[i].mack, e);
            waitDone(e, 400, lat, rdy);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_ready", i), rdy, 1);
            check($sformatf("v%0d_rdata", i), ifc.oRDATA, vecs[i].rdata);
            check($sformatf("v%0d_sack", i), ifc.oSACK, vecs[i].sack);
            repeat (2) @(posedge iCLK);
            #1;
            check($sformatf("v%0d_scl_idle", i), oSCL, vecs[i].scl);
            check($sformatf("v%0d_sda_idle", i), sdaLvl, vecs[i].sdaExp);
            if (vecs[i].chkCap) begin
                check($sformatf("v%0d_bus_byte", i), capByte, vecs[i].cap);
                check($sformatf("v%0d_bus_ackbit", i), ackBit, vecs[i].ackb);
            end
        end
        slaveMode = 2'd0;
        check("start_conditions", startCnt, 4);
        check("stop_conditions", stopCnt, 2);

        // Requests while busy must be ignored
        issue(2'b00, 8'h00, 1'b0, e);
        for (int k = 0; k < 4; k++) begin
            @(negedge iCLK);
            ifc.iCMD_VALID = 1'b1;
            ifc.iCMD       = 2'b01;
            check($sformatf("busy_ready_%0d", k), ifc.oCMD_READY, 0);
        end
        @(negedge iCLK);
        ifc.iCMD_VALID = 1'b0;
        waitDone(e, 300, lat, rdy);
        check("ignored_cmd_latency", lat, 17);
        check("ignored_cmd_scl", oSCL, 0);
        repeat (2) @(posedge iCLK);

        // Reset 40 cycles into a WRITE aborts it silently
        slaveMode = 2'd1;
        issue(2'b10, 8'hA5, 1'b0, e);
        repeat (39) @(posedge iCLK);
        @(negedge iCLK);
        iRESET = 1'b1;
        @(posedge iCLK);
        #1;
        check("abort_scl", oSCL, 1);
        check("abort_sda", sdaLvl, 1);
        check("abort_ready", ifc.oCMD_READY, 1);
        check("abort_done", ifc.oDONE, 0);
        @(negedge iCLK);
        iRESET   = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge iCLK);
            #1;
            if (ifc.oDONE) doneSeen++;
        end
        check("abort_no_done", doneSeen, 0);
        check("abort_stop_count", stopCnt, 2);
        slaveMode = 2'd0;

`ifdef I2C_MASTER_STRETCH_EN
        issue(2'b00, 8'h00, 1'b0, e);
        waitDone(e, 300, lat, rdy);
        repeat (2) @(posedge iCLK);
        slaveMode = 2'd1;
        issue(2'b10, 8'h81, 1'b0, e);
        lat = -1;
        for (int k = 0; k < 500; k++) begin
            @(posedge iCLK);
            #1;
            if (falls == 3 && oSCL) begin
                lat = k;
                break;
            end
        end
        check("stretch_found_bit3", lat >= 0, 1);
        stretchHold = 1'b1;
        repeat (10) @(posedge iCLK);
        #1;
        stretchHold = 1'b0;
        waitDone(e, 400, lat, rdy);
        check("stretch_latency", lat, 155);
        check("stretch_sack", ifc.oSACK, 1);
        slaveMode = 2'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
